sw_input_ctrl: RTL and testbench
================================

# sw_input_ctrl

Input controller for the board slide switches of the simple-machine I/O subsystem. Synchronises and debounces the raw switch bus, keeps a stable switch image, and flags any change. The processor side reads that image through a four-phase request/acknowledge handshake. The block replaces direct registered sampling of the switches. The processor sees only debounced values and can poll a change flag instead of comparing samples.

## Interface
- WIDTH, 8, number of switch inputs
- DEBOUNCE_CYCLES, 16, consecutive post-sync cycles a new level must persist before acceptance (≥2)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clock clk
- sw  input  WIDTH  raw asynchronous switch levels
- rd_req  input  1  processor read request (four-phase)
- rd_ack  output  1  one-cycle acknowledge; rd_data valid in the same cycle
- rd_data  output  WIDTH  switch snapshot returned by a read, held until next ack
- stable_sw  output  WIDTH  current debounced switch image, registered
- changed  output  1  sticky flag: stable_sw has changed since the last completed read

## Operation
- Per bit: two-flop synchroniser (s1, s2), then debounce counter of width clog2(DEBOUNCE_CYCLES).
- Debounce per bit, each edge:
  - s2 == stable_sw[i]: counter cleared to 0.
  - s2 != stable_sw[i] and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s2 != stable_sw[i] and counter == DEBOUNCE_CYCLES-1: stable_sw[i] <= s2, counter <= 0.
- Any mismatch gap restarts the count. A pulse shorter than DEBOUNCE_CYCLES cycles at s2 never reaches stable_sw.
- changed is set on any edge where at least one stable_sw bit updates. It is cleared on the edge that asserts rd_ack. If an update and the ack occur on the same edge, set wins and changed stays 1.
- Read FSM states:
  - IDLE: rd_req=1 → ACK.
  - ACK, one cycle: rd_ack=1. rd_data loaded at the IDLE→ACK edge with stable_sw as it is before that edge. Next state is WAIT.
  - WAIT: rd_req=0 → IDLE; otherwise stay.
- A request held high through WAIT produces exactly one ack. A new read requires rd_req low for at least one cycle.
- rd_req dropped during ACK: the ack still completes, then WAIT exits to IDLE on the next edge.

## Timing
- Reset values:
  - Outputs: stable_sw=0, rd_data=0, rd_ack=0, changed=0.
  - Internal: s1=s2=0, all counters 0, FSM=IDLE.
- Reset mid-operation: all of the above on the reset edge. An in-progress ack is aborted; a pending changed flag is lost.
- After reset release, switches already high are accepted like any change and set changed.
- Input latency: sw stable from before edge k → s2 updated at edge k+1 → stable_sw updated at edge k+1+DEBOUNCE_CYCLES. The same edge sets changed.
- Read latency: rd_req sampled high at edge n → rd_ack high during cycle n to n+1 (asserted by edge n) → deasserted at edge n+1.
- Minimum read cycle: 3 edges (IDLE→ACK→WAIT→IDLE with rd_req dropped in ACK).
- No combinational path from any input to any output.

## Test plan
- Reset with sw=8'hA5 held, DEBOUNCE_CYCLES=4: all outputs 0 on the reset edge. stable_sw=8'hA5 and changed=1 exactly 5 edges after the first edge with reset low.
- Glitch rejection, D=4, stable_sw=8'h00: sw[0] high for 3 cycles then low → stable_sw stays 8'h00 and changed stays 0. A 4-cycle pulse sets stable_sw=8'h01 and changed=1.
- Read: changed=1, stable_sw=8'h3C, rd_req raised and held 5 cycles → single one-cycle rd_ack with rd_data=8'h3C. changed cleared on the ack edge. A second ack is seen only after rd_req low then high again.
- Simultaneous: stable_sw update scheduled on the same edge as the ack → rd_data holds the pre-update value, stable_sw holds the new value, changed remains 1.
- Reset asserted during ACK → rd_ack=0, rd_data=0, changed=0 on that edge. The FSM returns to IDLE and the next request gets a normal ack.
- Per-bit independence, D=4: sw[7] toggles at cycle 0 and sw[1] at cycle 2 → stable_sw[7] updates 2 edges before stable_sw[1]. changed set at the first update.

Source files
------------

// File: rtl/sw_input_ctrl.sv
// Slide-switch input controller: synchronises and debounces the raw switch bus,
// keeps a stable switch image with a sticky change flag, and serves handshake reads.
module sw_input_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] stable_sw,
  output logic             changed
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT
  } state_t;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] upd;
  state_t           state;
  state_t           state_next;
  logic             load;

  // A bit is accepted once it has disagreed with the stable image for the full count.
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = (s2[i] != stable_sw[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      stable_sw <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= sw;
      s2 <= s1;
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == stable_sw[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          stable_sw[i] <= s2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          state_next = ACK;
          load       = 1'b1;
        end
      end
      ACK:  state_next = WAIT;
      WAIT: begin
        if (!rd_req) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rd_ack = (state == ACK);

  // An update on the same edge as the ack keeps the flag set so no change is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
      changed <= 1'b0;
    end else begin
      if (load) begin
        rd_data <= stable_sw;
      end
      if (|upd) begin
        changed <= 1'b1;
      end else if (load) begin
        changed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sw_input_ctrl.sv
// Self-checking bench for sw_input_ctrl: directed scenarios with literal
// expectations plus randomized stimulus compared every cycle against a reference model.
module tb_sw_input_ctrl;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sw = '0;
  logic         rd_req = 1'b0;
  logic         rd_ack;
  logic [W-1:0] rd_data;
  logic [W-1:0] stable_sw;
  logic         changed;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  sw_input_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .rd_req    (rd_req),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .stable_sw (stable_sw),
    .changed   (changed)
  );

  always #5 clk = ~clk;

  // Reference model: a stable bit flips once the synchronised level has
  // disagreed with it on D consecutive edges; reads are one ack per request.
  logic [W-1:0] m_s1, m_s2, m_stable, m_data;
  logic         m_ack, m_changed, m_armed;
  logic [W-1:0] hist [$];

  always @(posedge clk) begin
    logic [W-1:0] upd;
    logic         new_ack;
    bit           all_diff;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_data = '0;
      m_ack = 1'b0; m_changed = 1'b0; m_armed = 1'b1;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      upd = '0;
      if (hist.size() == D) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          foreach (hist[j]) if (hist[j][b] == m_stable[b]) all_diff = 1'b0;
          upd[b] = all_diff;
        end
      end
      new_ack = 1'b0;
      if (!m_ack) begin
        if (m_armed && rd_req) begin
          new_ack = 1'b1;
          m_armed = 1'b0;
          m_data  = m_stable;
        end else if (!m_armed && !rd_req) begin
          m_armed = 1'b1;
        end
      end
      if (|upd) m_changed = 1'b1;
      else if (new_ack) m_changed = 1'b0;
      m_stable = m_stable ^ upd;
      m_s2 = m_s1;
      m_s1 = sw;
      m_ack = new_ack;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkOutput("model stable_sw", 32'(stable_sw), 32'(m_stable));
      checkOutput("model changed",   32'(changed),   32'(m_changed));
      checkOutput("model rd_ack",    32'(rd_ack),    32'(m_ack));
      checkOutput("model rd_data",   32'(rd_data),   32'(m_data));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [W-1:0] s, input logic r);
    sw = s;
    rd_req = r;
  endtask

  task automatic doRead(input logic [W-1:0] exp_data);
    rd_req = 1'b1;
    cycles(1);
    checkOutput("read ack", 32'(rd_ack), 32'd1);
    checkOutput("read data", 32'(rd_data), 32'(exp_data));
    rd_req = 1'b0;
    cycles(2);
  endtask

  initial begin
    int acks;
    $display("[TB] start");
    applyStimulus(8'hA5, 1'b0);
    reset = 1'b1;
    cycles(1);
    started = 1'b1;
    checkOutput("reset stable_sw", 32'(stable_sw), 32'h0);
    checkOutput("reset rd_data", 32'(rd_data), 32'h0);
    checkOutput("reset rd_ack", 32'(rd_ack), 32'h0);
    checkOutput("reset changed", 32'(changed), 32'h0);
    cycles(2);
    reset = 1'b0;
    cycles(5);
    checkOutput("post-reset early", 32'(stable_sw), 32'h00);
    cycles(1);
    checkOutput("post-reset accept", 32'(stable_sw), 32'hA5);
    checkOutput("post-reset changed", 32'(changed), 32'h1);
    doRead(8'hA5);

    // Glitch rejection around the debounce threshold
    applyStimulus(8'h00, 1'b0);
    cycles(10);
    doRead(8'h00);
    checkOutput("glitch pre changed", 32'(changed), 32'h0);
    sw = 8'h01; cycles(3); sw = 8'h00; cycles(10);
    checkOutput("glitch3 stable", 32'(stable_sw), 32'h00);
    checkOutput("glitch3 changed", 32'(changed), 32'h0);
    sw = 8'h01; cycles(4); sw = 8'h00; cycles(2);
    checkOutput("pulse4 stable", 32'(stable_sw), 32'h01);
    checkOutput("pulse4 changed", 32'(changed), 32'h1);
    cycles(10);
    doRead(8'h00);

    // Held request yields a single ack
    sw = 8'h3C; cycles(10);
    checkOutput("3C stable", 32'(stable_sw), 32'h3C);
    rd_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      if (i == 0) begin
        checkOutput("held data", 32'(rd_data), 32'h3C);
        checkOutput("held changed cleared", 32'(changed), 32'h0);
      end
      if (rd_ack) acks++;
    end
    checkOutput("held ack count", 32'(acks), 32'd1);
    rd_req = 1'b0; cycles(1);
    rd_req = 1'b1; cycles(1);
    checkOutput("second ack", 32'(rd_ack), 32'd1);
    rd_req = 1'b0; cycles(2);

    // Update landing on the ack edge
    sw = 8'hC3; cycles(5);
    rd_req = 1'b1; cycles(1);
    checkOutput("simul ack", 32'(rd_ack), 32'd1);
    checkOutput("simul data", 32'(rd_data), 32'h3C);
    checkOutput("simul stable", 32'(stable_sw), 32'hC3);
    checkOutput("simul changed", 32'(changed), 32'h1);
    rd_req = 1'b0; cycles(2);
    doRead(8'hC3);

    // Reset during the ack cycle
    rd_req = 1'b1; cycles(1);
    checkOutput("pre-abort ack", 32'(rd_ack), 32'd1);
    reset = 1'b1; rd_req = 1'b0; cycles(1);
    checkOutput("abort ack", 32'(rd_ack), 32'd0);
    checkOutput("abort data", 32'(rd_data), 32'h0);
    checkOutput("abort changed", 32'(changed), 32'h0);
    reset = 1'b0; cycles(8);
    doRead(8'hC3);

    // Per-bit independence
    sw = 8'h43; cycles(2);
    sw = 8'h41; cycles(3);
    checkOutput("perbit early", 32'(stable_sw), 32'hC3);
    cycles(1);
    checkOutput("perbit bit7", 32'(stable_sw), 32'h43);
    checkOutput("perbit changed", 32'(changed), 32'h1);
    cycles(2);
    checkOutput("perbit bit1", 32'(stable_sw), 32'h41);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      logic [W-1:0] flips;
      flips = '0;
      for (int b = 0; b < W; b++) flips[b] = ($urandom_range(0, 5) == 0);
      sw = sw ^ flips;
      if ($urandom_range(0, 2) == 0) rd_req = ~rd_req;
      reset = ($urandom_range(0, 199) == 0);
      cycles(1);
    end
    reset = 1'b0;
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
